// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - state enum, datapath select encodings and condition codes for the multicycle control unit
package control_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH,
    S_LINKWB
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  // funct[4:1] opcodes of the data-processing instructions
  localparam logic [3:0] FN_ADD = 4'b0100;
  localparam logic [3:0] FN_SUB = 4'b0010;
  localparam logic [3:0] FN_AND = 4'b0000;
  localparam logic [3:0] FN_ORR = 4'b1100;
  localparam logic [3:0] FN_EOR = 4'b0001;
  localparam logic [3:0] FN_CMP = 4'b1010;
  localparam logic [3:0] FN_TST = 4'b1000;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] REGSRC_LINK = 2'b11;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'hA;
  localparam logic [3:0] COND_LT = 4'hB;
  localparam logic [3:0] COND_GT = 4'hC;
  localparam logic [3:0] COND_LE = 4'hD;
  localparam logic [3:0] COND_AL = 4'hE;

  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, r;
    n = nzcv[3];
    z = nzcv[2];
    c = nzcv[1];
    v = nzcv[0];
    case (cond)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = c;
      COND_CC: r = ~c;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = c & ~z;
      COND_LS: r = ~c | z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = z | (n != v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/condlogic_mc.sv
// rtl/condlogic_mc.sv - NZCV flags register, condition evaluation and gating of architectural write enables
module condlogic_mc
  import control_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] cond_i,
  input  logic [3:0] alu_flags_i,
  input  logic [1:0] flag_w_i,
  input  logic       pc_uncond_i,
  input  logic       pcs_i,
  input  logic       reg_w_i,
  input  logic       mem_w_i,
  output logic       cond_ex_o,
  output logic       pc_write_o,
  output logic       reg_write_o,
  output logic       mem_write_o
);

  logic [3:0] flags_q, flags_d;

  assign cond_ex_o = cond_eval(cond_i, flags_q);

  // flag_w_i[1] updates N,Z; flag_w_i[0] updates C,V
  always_comb begin
    flags_d = flags_q;
    if (flag_w_i[1] && cond_ex_o) flags_d[3:2] = alu_flags_i[3:2];
    if (flag_w_i[0] && cond_ex_o) flags_d[1:0] = alu_flags_i[1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) flags_q <= 4'b0000;
    else       flags_q <= flags_d;
  end

  assign pc_write_o  = ~reset & (pc_uncond_i | (pcs_i & cond_ex_o));
  assign reg_write_o = ~reset & reg_w_i & cond_ex_o;
  assign mem_write_o = ~reset & mem_w_i & cond_ex_o;

endmodule

// File: rtl/unidad_control_multiciclo.sv
// rtl/unidad_control_multiciclo.sv - multicycle ARM-subset main FSM and instruction decode
// Defining BRANCH_LINK_EN adds the LINKWB state so BL writes the return address to R14.
module unidad_control_multiciclo
  import control_pkg::*;
#(
  parameter int ALUCTRL_W = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [19:0]          Instr,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic                 RegWrite,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl
);

  state_t     state_q, state_d, state_eff;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] fn;
  logic       unused_instr;

  assign cond         = Instr[19:16];
  assign op           = Instr[15:14];
  assign funct        = Instr[13:8];
  assign fn           = funct[4:1];
  assign unused_instr = ^Instr[7:0];

  logic       dp_def, dp_nowrite, dp_cv, dp_force;
  logic [2:0] dp_alu;

  always_comb begin
    dp_def     = 1'b1;
    dp_alu     = ALU_ADD;
    dp_nowrite = 1'b0;
    dp_cv      = 1'b0;
    dp_force   = 1'b0;
    case (fn)
      FN_ADD: begin dp_alu = ALU_ADD; dp_cv = 1'b1; end
      FN_SUB: begin dp_alu = ALU_SUB; dp_cv = 1'b1; end
      FN_AND: dp_alu = ALU_AND;
      FN_ORR: dp_alu = ALU_ORR;
      FN_EOR: begin
        if (ALUCTRL_W > 2) dp_alu = ALU_EOR;
        else               dp_def = 1'b0;
      end
      FN_CMP: begin
        if (ALUCTRL_W > 2) begin
          dp_alu = ALU_SUB; dp_cv = 1'b1; dp_nowrite = 1'b1; dp_force = 1'b1;
        end else dp_def = 1'b0;
      end
      FN_TST: begin
        if (ALUCTRL_W > 2) begin
          dp_alu = ALU_AND; dp_nowrite = 1'b1; dp_force = 1'b1;
        end else dp_def = 1'b0;
      end
      default: dp_def = 1'b0;
    endcase
    if (!dp_def) dp_alu = ALU_ADD;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: state_d = funct[0] ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_EXECR,
      S_EXECI:  state_d = S_ALUWB;
`ifdef BRANCH_LINK_EN
      S_BRANCH: state_d = funct[4] ? S_LINKWB : S_FETCH;
`else
      S_BRANCH: state_d = S_FETCH;
`endif
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  // Outputs decode as FETCH while reset is held, even before the state register catches up
  assign state_eff = reset ? S_FETCH : state_q;

  logic       irw, pc_uncond, pcs, regw, memw;
  logic [1:0] flagw;
  logic [2:0] alu_sel;

  always_comb begin
    irw       = 1'b0;
    pc_uncond = 1'b0;
    pcs       = 1'b0;
    regw      = 1'b0;
    memw      = 1'b0;
    flagw     = 2'b00;
    AdrSrc    = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = 1'b0;
    ALUSrcB   = SRCB_REG;
    alu_sel   = ALU_ADD;
    RegSrc    = {op == OP_MEM, op == OP_BR};
    ImmSrc    = op;
    case (state_eff)
      S_FETCH: begin
        irw = 1'b1; pc_uncond = 1'b1;
        ResultSrc = RES_ALURESULT; ALUSrcA = 1'b1; ALUSrcB = SRCB_FOUR;
      end
      S_DECODE: begin
        ResultSrc = RES_ALURESULT; ALUSrcA = 1'b1; ALUSrcB = SRCB_FOUR;
      end
      S_MEMADR: ALUSrcB = SRCB_IMM;
      S_MEMRD:  AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = RES_DATA; regw = 1'b1;
      end
      S_MEMWR: begin
        AdrSrc = 1'b1; memw = 1'b1;
      end
      S_EXECR, S_EXECI: begin
        ALUSrcB = (state_eff == S_EXECI) ? SRCB_IMM : SRCB_REG;
        alu_sel = dp_alu;
        if (dp_def) flagw = {funct[0] | dp_force, (funct[0] | dp_force) & dp_cv};
      end
      S_ALUWB: regw = dp_def & ~dp_nowrite;
      S_BRANCH: begin
        ALUSrcB = SRCB_IMM; ResultSrc = RES_ALURESULT; pcs = 1'b1;
      end
      S_LINKWB: begin
        RegSrc = REGSRC_LINK; ResultSrc = RES_ALURESULT;
        ALUSrcA = 1'b1; ALUSrcB = SRCB_FOUR; alu_sel = ALU_SUB; regw = 1'b1;
      end
      default: ;
    endcase
  end

  assign IRWrite    = irw & ~reset;
  assign ALUControl = alu_sel[ALUCTRL_W-1:0];

  logic cond_ex;

  condlogic_mc u_cond (
    .clk         (clk),
    .reset       (reset),
    .cond_i      (cond),
    .alu_flags_i (ALUFlags),
    .flag_w_i    (flagw),
    .pc_uncond_i (pc_uncond),
    .pcs_i       (pcs),
    .reg_w_i     (regw),
    .mem_w_i     (memw),
    .cond_ex_o   (cond_ex),
    .pc_write_o  (PCWrite),
    .reg_write_o (RegWrite),
    .mem_write_o (MemWrite)
  );

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// tb/tb_unidad_control_multiciclo.sv - table-driven scoreboard bench for the multicycle control unit
`timescale 1ns/1ps
module tb_unidad_control_multiciclo;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [19:0] Instr = '0;
  logic [3:0]  ALUFlags = '0;

  logic       PCWrite, AdrSrc, MemWrite, IRWrite, ALUSrcA, RegWrite;
  logic [1:0] ResultSrc, ALUSrcB, ImmSrc, RegSrc;
  logic [2:0] ALUControl;

  logic       PCWrite2, AdrSrc2, MemWrite2, IRWrite2, ALUSrcA2, RegWrite2;
  logic [1:0] ResultSrc2, ALUSrcB2, ImmSrc2, RegSrc2;
  logic [1:0] ALUControl2;

  always #5 clk = ~clk;

  unidad_control_multiciclo #(.ALUCTRL_W(3)) dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl)
  );

  unidad_control_multiciclo #(.ALUCTRL_W(2)) dut2 (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
    .PCWrite(PCWrite2), .AdrSrc(AdrSrc2), .MemWrite(MemWrite2), .IRWrite(IRWrite2),
    .ResultSrc(ResultSrc2), .ALUSrcA(ALUSrcA2), .ALUSrcB(ALUSrcB2), .RegWrite(RegWrite2),
    .ImmSrc(ImmSrc2), .RegSrc(RegSrc2), .ALUControl(ALUControl2)
  );

  // Per-cycle observation: {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc}
  logic [4:0] obs;
  assign obs = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc};

  localparam logic [4:0] C_F   = 5'b11000;
  localparam logic [4:0] C_0   = 5'b00000;
  localparam logic [4:0] C_RW  = 5'b00010;
  localparam logic [4:0] C_MRD = 5'b00001;
  localparam logic [4:0] C_MWR = 5'b00101;
  localparam logic [4:0] C_BR  = 5'b10000;

  typedef struct {
    logic [19:0]     instr;
    logic [3:0]      flags;
    int              n;
    logic [4:0][4:0] c;
    int              alu_cyc;
    logic [2:0]      alu;
  } vec_t;

  typedef struct {
    logic [4:0] w;
    logic [2:0] alu;
    bit         chk;
    int         tag;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  function automatic logic [19:0] enc(input logic [3:0] cond, input logic [1:0] op, input logic [5:0] funct);
    return {cond, op, funct, 8'h21};
  endfunction

  function automatic vec_t mkv(input logic [19:0] instr, input logic [3:0] flags, input int n,
                               input logic [4:0] c0, input logic [4:0] c1, input logic [4:0] c2,
                               input logic [4:0] c3, input logic [4:0] c4,
                               input int alu_cyc, input logic [2:0] alu);
    vec_t v;
    v.instr = instr; v.flags = flags; v.n = n;
    v.c[0] = c0; v.c[1] = c1; v.c[2] = c2; v.c[3] = c3; v.c[4] = c4;
    v.alu_cyc = alu_cyc; v.alu = alu;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s got=%b want=%b", nm, got, want);
    end
  endtask

  task automatic step();
    exp_t e;
    @(negedge clk);
    compared++;
    if (sb.size() == 0) begin
      mismatched++;
      $display("FAIL scoreboard_empty got=%b want=none", obs);
    end else begin
      e = sb.pop_front();
      if (obs !== e.w) begin
        mismatched++;
        $display("FAIL writes vec=%0d got=%b want=%b", e.tag, obs, e.w);
      end
      if (e.chk) begin
        compared++;
        if (ALUControl !== e.alu) begin
          mismatched++;
          $display("FAIL alucontrol vec=%0d got=%b want=%b", e.tag, ALUControl, e.alu);
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic run_vec(input vec_t v, input int tag);
    exp_t e;
    Instr = v.instr;
    ALUFlags = v.flags;
    for (int i = 0; i < v.n && i < 5; i++) begin
      e.w = v.c[i]; e.alu = v.alu; e.chk = (i == v.alu_cyc); e.tag = tag;
      sb.push_back(e);
    end
    for (int i = 0; i < v.n && i < 5; i++) step();
  endtask

  initial begin
    vecs.push_back(mkv(enc(4'hE, 2'b00, 6'b001000), 4'b0000, 4, C_F, C_0, C_0, C_RW, C_0, 2, 3'b000)); // ADD
    vecs.push_back(mkv(enc(4'hE, 2'b00, 6'b010101), 4'b0100, 4, C_F, C_0, C_0, C_0, C_0, 2, 3'b001));  // CMP -> 0100
    vecs.push_back(mkv(enc(4'h0, 2'b10, 6'b000000), 4'b0000, 3, C_F, C_0, C_BR, C_0, C_0, -1, 3'b000)); // BEQ taken
    vecs.push_back(mkv(enc(4'hE, 2'b00, 6'b010101), 4'b0000, 4, C_F, C_0, C_0, C_0, C_0, 2, 3'b001));  // CMP -> 0000
    vecs.push_back(mkv(enc(4'h0, 2'b10, 6'b000000), 4'b0000, 3, C_F, C_0, C_0, C_0, C_0, -1, 3'b000));  // BEQ not taken
    vecs.push_back(mkv(enc(4'h0, 2'b01, 6'b011001), 4'b0000, 5, C_F, C_0, C_0, C_MRD, C_0, 2, 3'b000)); // LDREQ skipped
    vecs.push_back(mkv(enc(4'hE, 2'b01, 6'b011000), 4'b0000, 4, C_F, C_0, C_0, C_MWR, C_0, 2, 3'b000)); // STR
    vecs.push_back(mkv(enc(4'hE, 2'b01, 6'b011001), 4'b0000, 5, C_F, C_0, C_0, C_MRD, C_RW, -1, 3'b000)); // LDR
    vecs.push_back(mkv(enc(4'hE, 2'b00, 6'b111000), 4'b0000, 4, C_F, C_0, C_0, C_RW, C_0, 2, 3'b011)); // ORR imm
    vecs.push_back(mkv(enc(4'hE, 2'b00, 6'b000101), 4'b0110, 4, C_F, C_0, C_0, C_RW, C_0, 2, 3'b001)); // SUBS -> 0110
    vecs.push_back(mkv(enc(4'h8, 2'b10, 6'b000000), 4'b0000, 3, C_F, C_0, C_0, C_0, C_0, -1, 3'b000));  // BHI no
    vecs.push_back(mkv(enc(4'h9, 2'b10, 6'b000000), 4'b0000, 3, C_F, C_0, C_BR, C_0, C_0, -1, 3'b000)); // BLS yes
    vecs.push_back(mkv(enc(4'hE, 2'b00, 6'b000001), 4'b1001, 4, C_F, C_0, C_0, C_RW, C_0, 2, 3'b010)); // ANDS -> 1010
    vecs.push_back(mkv(enc(4'h2, 2'b10, 6'b000000), 4'b0000, 3, C_F, C_0, C_BR, C_0, C_0, -1, 3'b000)); // BCS yes
    vecs.push_back(mkv(enc(4'h4, 2'b10, 6'b000000), 4'b0000, 3, C_F, C_0, C_BR, C_0, C_0, -1, 3'b000)); // BMI yes
    vecs.push_back(mkv(enc(4'h6, 2'b10, 6'b000000), 4'b0000, 3, C_F, C_0, C_0, C_0, C_0, -1, 3'b000));  // BVS no
    vecs.push_back(mkv(enc(4'hE, 2'b00, 6'b010000), 4'b0100, 4, C_F, C_0, C_0, C_0, C_0, 2, 3'b010));  // TST -> 0110
    vecs.push_back(mkv(enc(4'h0, 2'b10, 6'b000000), 4'b0000, 3, C_F, C_0, C_BR, C_0, C_0, -1, 3'b000)); // BEQ yes
    vecs.push_back(mkv(enc(4'hE, 2'b11, 6'b000000), 4'b0000, 2, C_F, C_0, C_0, C_0, C_0, -1, 3'b000));  // undefined op
    vecs.push_back(mkv(enc(4'hE, 2'b00, 6'b000010), 4'b1111, 4, C_F, C_0, C_0, C_RW, C_0, 2, 3'b100)); // EOR
    vecs.push_back(mkv(enc(4'hF, 2'b00, 6'b001000), 4'b0000, 4, C_F, C_0, C_0, C_0, C_0, 2, 3'b000));  // cond 1111
    vecs.push_back(mkv(enc(4'hE, 2'b00, 6'b001110), 4'b0000, 4, C_F, C_0, C_0, C_0, C_0, 2, 3'b000));  // bad funct
    vecs.push_back(mkv(enc(4'h0, 2'b00, 6'b001001), 4'b0000, 4, C_F, C_0, C_0, C_0, C_0, 2, 3'b000));  // ADDSEQ clears Z
`ifdef BRANCH_LINK_EN
    vecs.push_back(mkv(enc(4'hE, 2'b10, 6'b010000), 4'b0000, 4, C_F, C_0, C_BR, C_RW, C_0, -1, 3'b000)); // BL
`else
    vecs.push_back(mkv(enc(4'hE, 2'b10, 6'b010000), 4'b0000, 3, C_F, C_0, C_BR, C_0, C_0, -1, 3'b000));  // BL as B
`endif
    vecs.push_back(mkv(enc(4'hA, 2'b10, 6'b000000), 4'b0000, 3, C_F, C_0, C_BR, C_0, C_0, -1, 3'b000)); // BGE yes
    vecs.push_back(mkv(enc(4'hB, 2'b10, 6'b000000), 4'b0000, 3, C_F, C_0, C_0, C_0, C_0, -1, 3'b000));  // BLT no
    vecs.push_back(mkv(enc(4'hC, 2'b10, 6'b000000), 4'b0000, 3, C_F, C_0, C_BR, C_0, C_0, -1, 3'b000)); // BGT yes
    vecs.push_back(mkv(enc(4'hD, 2'b10, 6'b000000), 4'b0000, 3, C_F, C_0, C_0, C_0, C_0, -1, 3'b000));  // BLE no

    reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("reset_write_enables", {4'b0, PCWrite, IRWrite, MemWrite, RegWrite}, 8'h00);
      chk("reset_fetch_selects", {2'b0, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc}, 8'b00_0_1_10_10);
      @(posedge clk); #1;
    end
    reset = 1'b0;

    for (int k = 0; k < vecs.size(); k++) run_vec(vecs[k], k);

    // Reset arriving while an LDR sits in MEMRD
    run_vec(mkv(enc(4'hE, 2'b01, 6'b011001), 4'b0000, 3, C_F, C_0, C_0, C_0, C_0, 2, 3'b000), 100);
    @(negedge clk);
    chk("memrd_adrsrc", {7'b0, AdrSrc}, 8'h01);
    chk("memrd_writes", {4'b0, PCWrite, IRWrite, MemWrite, RegWrite}, 8'h00);
    #1 reset = 1'b1;
    #1 chk("midreset_writes", {4'b0, PCWrite, IRWrite, MemWrite, RegWrite}, 8'h00);
    @(posedge clk); #1;
    reset = 1'b0;
    Instr = enc(4'hE, 2'b00, 6'b000011);
    ALUFlags = 4'b0100;
    @(negedge clk);
    chk("after_reset_is_fetch", {3'b0, obs}, {3'b0, C_F});
    @(posedge clk); #1;

    // EORS: legal on the 3-bit build, undefined on the 2-bit build
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("eor_alu_w3", {5'b0, ALUControl}, 8'b100);
    chk("eor_alu_w2", {6'b0, ALUControl2}, 8'b00);
    @(posedge clk); #1;
    @(negedge clk);
    chk("eor_regwrite_w3", {7'b0, RegWrite}, 8'h01);
    chk("eor_regwrite_w2", {7'b0, RegWrite2}, 8'h00);
    @(posedge clk); #1;
    Instr = enc(4'h0, 2'b10, 6'b000000);
    ALUFlags = 4'b0000;
    repeat (2) begin
      @(negedge clk);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("beq_after_eors_w3", {7'b0, PCWrite}, 8'h01);
    chk("beq_after_eors_w2", {7'b0, PCWrite2}, 8'h00);
    @(posedge clk); #1;
    @(negedge clk);
    chk("next_fetch_both", {6'b0, IRWrite, IRWrite2}, 8'b11);

    if (sb.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL scoreboard_leftover got=%0d want=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/unidad_control_multiciclo.md
# unidad_control_multiciclo

Multicycle control unit for the ARM-subset processor. A main state machine sequences each instruction through fetch, decode, execute, memory and writeback over several cycles, so one shared memory and one ALU serve the whole datapath. Conditional-execution logic gates every architectural write using registered NZCV flags. The ALU-op width is parametrised so that EOR, CMP and TST are supported on top of the existing ADD/SUB/AND/ORR set.

## Interface
- ALUCTRL_W, default 3, width of ALUControl; legal values 2 (ADD/SUB/AND/ORR) or 3 (adds EOR, CMP, TST)
- clk  input  1  single clock; all state changes on the rising edge
- reset  input  1  synchronous, active-high reset
- Instr  input  20  IR bits [31:12]: cond, op, funct, Rd
- ALUFlags  input  4  NZCV from the ALU, current cycle
- PCWrite  output  1  PC load enable
- AdrSrc  output  1  memory address select: 0 = PC, 1 = ALU result register
- MemWrite  output  1  data memory write enable
- IRWrite  output  1  instruction register load enable
- ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  output  1  0 = register A, 1 = PC
- ALUSrcB  output  2  00 = register, 01 = ExtImm, 10 = constant 4
- RegWrite  output  1  register file write enable
- ImmSrc  output  2  extend mode (same encoding as the datapath)
- RegSrc  output  2  register-address selects (same encoding as the datapath)
- ALUControl  output  ALUCTRL_W  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR

## Operation
- FSM states:
  - FETCH: IRWrite=1, PCWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ADD. Next state is DECODE.
  - DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, which precomputes PC+8.
  - DECODE branches on op:
    - op=01 goes to MEMADR.
    - op=00 goes to EXECR when funct[5]=0, and to EXECI when funct[5]=1.
    - op=10 goes to BRANCH.
    - op=11 goes back to FETCH; the instruction is undefined and nothing is written.
- MEMADR: ALUSrcB=01, ADD. The next state is MEMRD when funct[0]=1 (LDR) and MEMWR otherwise.
- MEMRD: AdrSrc=1. Next state is MEMWB.
- MEMWB: ResultSrc=01, RegWrite=CondEx. Next state is FETCH.
- MEMWR: AdrSrc=1, MemWrite=CondEx. Next state is FETCH.
- EXECR uses ALUSrcB=00; EXECI uses ALUSrcB=01. Both take ALUControl from funct[4:1]:
  - ADD 0100, SUB 0010, AND 0000, ORR 1100, EOR 0001.
  - CMP 1010 drives SUB; TST 1000 drives AND. Both are flags-only.
- Both EXECR and EXECI go to ALUWB next.
- ALUWB: ResultSrc=00, RegWrite=CondEx & ~NoWrite. NoWrite=1 for CMP and TST. Next state is FETCH.
- BRANCH: ALUSrcB=01, ResultSrc=10, PCWrite=CondEx. Next state is FETCH.
- Flags register (NZCV, 4 bits):
  - Written at the end of EXECR/EXECI only when funct[0]=1 (S bit) and CondEx=1.
  - N and Z come from ALUFlags[3:2]; C and V come from ALUFlags[1:0].
  - C and V are written only for ADD, SUB and CMP.
  - CMP and TST always write flags, regardless of the S bit.
- CondEx is combinational from Instr[31:28] and the registered flags. It supports all 15 ARM codes, EQ through AL; cond=1111 evaluates to 0.
- With ALUCTRL_W=2, EOR, CMP and TST are undefined: ALUWB is entered with RegWrite=0, no flag update, ALUControl=00.
- Any funct[4:1] value outside the supported set is handled as undefined in the same way.
- Rd=1111 (PC) with a data-processing or LDR writeback is not supported: RegWrite behaves normally and PC is not written.

## Timing
- Cycle counts, FETCH inclusive:
  - LDR 5
  - STR 4
  - Data-processing 4
  - B 3
  - Undefined 2
- While reset=1: state is forced to FETCH, flags are cleared to 0000, and PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
- All other outputs show their FETCH values during reset.
- FETCH is first executed in the first cycle after reset falls.
- A reset mid-instruction aborts it at the next edge, with no further writes.
- All outputs are decoded from the current state and Instr (Moore plus Instr decode). There are no registered outputs except the state and the flags.
- A flag update at the end of EXECR/EXECI is visible to CondEx in the following ALUWB and in the next instruction.

## Configuration
- BRANCH_LINK_EN defined:
  - BL (op=10, funct[4]=1) passes through BRANCH, then LINKWB.
  - LINKWB: RegSrc forces Rd=14, ResultSrc=10 writes the PC-4 value, RegWrite=CondEx. Next state is FETCH.
  - BL takes 4 cycles.
- BRANCH_LINK_EN undefined: BL behaves as plain B; R14 is never written and BL takes 3 cycles.

## Structure
- Package control_pkg holds:
  - the state enum
  - ALUControl encodings
  - condition-code constants
  - ResultSrc and ALUSrcB encodings
- One sub-module, condlogic_mc, holds the flags register, CondEx evaluation and the gating of write enables.
- The FSM and instruction decode stay in the top module.

## Test plan
- Reset held 3 cycles, then released → PCWrite=1 and IRWrite=1 on the first cycle after release; flags=0000.
- ADD R1,R2,R3 (cond=1110) → state sequence FETCH, DECODE, EXECR, ALUWB; RegWrite=1 only in ALUWB; ALUControl=000.
- CMP with ALUFlags=0100, followed by BEQ → flags=0100; RegWrite never asserted; branch taken with PCWrite=1 in BRANCH.
- Same sequence with ALUFlags=0000 → no PCWrite in BRANCH; next state is FETCH.
- LDR with cond=0000 and Z=0 → 5 cycles; RegWrite=0 in MEMWB.
- STR with cond=1110 → MemWrite=1 only in MEMWR.
- EOR with ALUCTRL_W=2 → RegWrite=0 and no flag change.
- With BRANCH_LINK_EN defined: BL → LINKWB reached and RegWrite=1 there.
- Reset asserted during MEMRD → state is FETCH at the next edge; RegWrite=0 in that cycle.
